// File: rtl/expr_feeder_pkg.sv
// expr_feeder_pkg: shared constants, error codes and state encoding for the expression feeder.
package expr_feeder_pkg;
    localparam int BUF_DEPTH = 15;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_OPEN  = 8'h28;
    localparam logic [7:0] CH_CLOSE = 8'h29;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_ADD   = 8'h2B;
    localparam logic [7:0] CH_SUB   = 8'h2D;
    localparam logic [1:0] ERR_EMPTY = 2'b00;
    localparam logic [1:0] ERR_BAD   = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;
    localparam logic [1:0] ERR_PAREN = 2'b11;
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        WAIT    = 2'd2,
        REJECT  = 2'd3
    } state_e;
endpackage

// File: rtl/expr_feeder_char_classify.sv
// char_classify: maps an ASCII character to its expression-grammar class.
module char_classify
    import expr_feeder_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic       legal_o,
    output logic       is_open_o,
    output logic       is_close_o,
    output logic       is_eq_o
);
    assign is_open_o  = ch_i == CH_OPEN;
    assign is_close_o = ch_i == CH_CLOSE;
    assign is_eq_o    = ch_i == CH_EQ;
    assign legal_o    = (ch_i >= 8'h30 && ch_i <= 8'h39) || (ch_i >= 8'h61 && ch_i <= 8'h66) ||
                        is_open_o || is_close_o || ch_i == CH_MUL || ch_i == CH_ADD || ch_i == CH_SUB;
endmodule

// File: rtl/expr_feeder.sv
// expr_feeder: buffers and validates an ASCII expression, then streams it to the calculator
// and waits for its result before accepting the next one.
module expr_feeder
    import expr_feeder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    input  logic       aec_valid,
    output logic       start,
    output logic [7:0] ascii_out,
    output logic       err,
    output logic [1:0] err_code
);
    state_e     state_q;
    logic [7:0] buf_q [BUF_DEPTH];
    logic [3:0] len_q, depth_q;
    logic [4:0] idx_q;
    logic       bad_q, ovf_q, imb_q;
    logic       in_ready_q, start_q, err_q;
    logic [7:0] ascii_q;
    logic [1:0] err_code_q;
    logic       legal, is_open, is_close, is_eq;
    logic       accept, full, store, reject_now;
    logic [1:0] rej_code;

    char_classify u_cls (
        .ch_i      (in_char),
        .legal_o   (legal),
        .is_open_o (is_open),
        .is_close_o(is_close),
        .is_eq_o   (is_eq)
    );

    assign accept     = in_valid && in_ready_q && state_q == COLLECT;
    assign full       = len_q == 4'(BUF_DEPTH);
    assign store      = accept && !is_eq && !full;
    assign reject_now = bad_q || ovf_q || imb_q || len_q == 4'd0 || depth_q != 4'd0;
    assign rej_code   = len_q == 4'd0 ? ERR_EMPTY : bad_q ? ERR_BAD : ovf_q ? ERR_OVF : ERR_PAREN;

    assign in_ready  = in_ready_q;
    assign start     = start_q;
    assign ascii_out = ascii_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

    // Buffer contents are don't-care after reset, so it stays out of the reset domain.
    always_ff @(posedge clk) begin
        if (store) buf_q[len_q] <= in_char;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            in_ready_q <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_EMPTY;
            ascii_q    <= 8'h00;
            len_q      <= 4'd0;
            depth_q    <= 4'd0;
            idx_q      <= 5'd0;
            bad_q      <= 1'b0;
            ovf_q      <= 1'b0;
            imb_q      <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_EMPTY;
            ascii_q    <= 8'h00;
            in_ready_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (accept && is_eq) begin
                        in_ready_q <= 1'b0;
                        if (reject_now) begin
                            state_q    <= REJECT;
                            err_q      <= 1'b1;
                            err_code_q <= rej_code;
                        end else begin
                            state_q <= SEND;
                            ascii_q <= buf_q[0];
                            start_q <= 1'b1;
                            idx_q   <= 5'd1;
                        end
                    end else if (accept) begin
                        if (full) ovf_q <= 1'b1;
                        else len_q <= len_q + 4'd1;
                        if (!legal) bad_q <= 1'b1;
                        if (is_open) depth_q <= depth_q + 4'd1;
                        else if (is_close && depth_q == 4'd0) imb_q <= 1'b1;
                        else if (is_close) depth_q <= depth_q - 4'd1;
                    end
                end
                SEND: begin
                    // idx runs one past len so the '=' marker gets its own cycle.
                    if (idx_q < {1'b0, len_q}) begin
                        ascii_q <= buf_q[idx_q[3:0]];
                        idx_q   <= idx_q + 5'd1;
                    end else if (idx_q == {1'b0, len_q}) begin
                        ascii_q <= CH_EQ;
                        idx_q   <= idx_q + 5'd1;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (aec_valid) begin
                        state_q    <= COLLECT;
                        in_ready_q <= 1'b1;
                        len_q      <= 4'd0;
                        depth_q    <= 4'd0;
                        idx_q      <= 5'd0;
                        bad_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                        imb_q      <= 1'b0;
                    end
                end
                REJECT: begin
                    state_q    <= COLLECT;
                    in_ready_q <= 1'b1;
                    len_q      <= 4'd0;
                    depth_q    <= 4'd0;
                    idx_q      <= 5'd0;
                    bad_q      <= 1'b0;
                    ovf_q      <= 1'b0;
                    imb_q      <= 1'b0;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_expr_feeder.sv
// tb_expr_feeder: directed self-checking bench for expr_feeder.
module tb_expr_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       aec_valid = 1'b0;
    logic       in_ready, start, err;
    logic [7:0] ascii_out;
    logic [1:0] err_code;
    int checks = 0;
    int failures = 0;

    expr_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_ready (in_ready),
        .aec_valid(aec_valid),
        .start    (start),
        .ascii_out(ascii_out),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c);
        in_valid = 1'b1;
        in_char  = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            if (i != 0) repeat (gap) step();
            drive(c);
        end
    endtask

    task automatic expect_stream(input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            check($sformatf("stream_byte%0d", i), ascii_out, c);
            check($sformatf("stream_start%0d", i), start, i == 0);
            check("stream_in_ready", in_ready, 0);
            check("stream_err", err, 0);
            step();
        end
        check("wait_ascii", ascii_out, 0);
        check("wait_in_ready", in_ready, 0);
    endtask

    task automatic release_wait();
        repeat (3) step();
        check("hold_in_ready", in_ready, 0);
        check("hold_ascii", ascii_out, 0);
        aec_valid = 1'b1;
        step();
        aec_valid = 1'b0;
        check("after_aec_in_ready", in_ready, 1);
    endtask

    task automatic expect_err(input logic [1:0] code);
        check("err_pulse", err, 1);
        check("err_code", err_code, code);
        check("err_ascii", ascii_out, 0);
        check("err_start", start, 0);
        step();
        check("err_cleared", err, 0);
        check("err_back_collect", in_ready, 1);
    endtask

    initial begin
        repeat (2) step();
        check("rst_ascii", ascii_out, 0);
        check("rst_start", start, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);

        send_str("3+4*2=", 0);
        expect_stream("3+4*2=");
        release_wait();

        send_str("(a-1)=", 2);
        expect_stream("(a-1)=");
        release_wait();

        drive("=");
        expect_err(2'b00);
        send_str("3 +1=", 0);
        expect_err(2'b01);
        send_str("1+)(=", 0);
        expect_err(2'b11);
        send_str("1234567890123456=", 0);
        expect_err(2'b10);

        aec_valid = 1'b1;
        step();
        aec_valid = 1'b0;
        check("aec_ignored_in_ready", in_ready, 1);
        send_str("5=", 0);
        expect_stream("5=");
        release_wait();

        send_str("1+2=", 0);
        check("abort_first", ascii_out, 8'h31);
        check("abort_first_start", start, 1);
        step();
        check("abort_second", ascii_out, 8'h2B);
        rst = 1'b1;
        #1;
        check("abort_ascii", ascii_out, 0);
        check("abort_start", start, 0);
        check("abort_err", err, 0);
        step();
        rst = 1'b0;
        step();
        check("abort_no_err", err, 0);
        check("abort_in_ready", in_ready, 1);
        send_str("7-8=", 1);
        expect_stream("7-8=");
        release_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
